ladder_sequencer: RTL and testbench
===================================

LADDER_SEQUENCER -- requirements
Module: ladder_sequencer

Interface
REQ-001 SHALL have parameter BUS_W, default 56: load/drain word width.
REQ-002 SHALL have parameter KEY_W, default 448: scalar/coordinate width; KEY_W % BUS_W == 0.
REQ-003 SHALL have parameter CNT_W, default 9: bit-counter width; 2^CNT_W > KEY_W.
REQ-004 SHALL have parameter BASE_X, default 448'h5: u-coordinate of the base point.
REQ-005 SHALL have ports:
  clk  in  1  single clock, all logic rising-edge
  reset  in  1  synchronous, active-high
  load_valid  in  1  scalar word valid
  load_data  in  BUS_W  scalar word, least significant word first
  load_ready  out  1  sequencer accepts scalar word
  start  in  1  begin ladder (sampled in ARMED only)
  bit_count  in  CNT_W  number of scalar bits to process, sampled at start
  step_start  out  1  one-cycle pulse to step engine
  step_dbl_x, step_dbl_z, step_add_x, step_add_z  out  KEY_W  step operands
  step_base_x  out  KEY_W  constant BASE_X
  step_done  in  1  step engine result valid, one cycle
  res_dbl_x, res_dbl_z, res_add_x, res_add_z  in  KEY_W  step results
  out_valid  out  1  result word valid
  out_data  out  BUS_W  result word
  out_ready  in  1  consumer accepts result word
  busy  out  1  high outside IDLE/ARMED
  done  out  1  one-cycle pulse after last result word accepted
  error  out  1  scalar-consistency fault, sticky until reset or next load

Function
REQ-006 SHALL implement states IDLE, LOAD, ARMED, ISSUE, WAIT, CHECK, DRAIN.
REQ-007 IDLE: load_ready=1; a load_valid&load_ready beat stores word 0, clears error, enters LOAD.
REQ-008 LOAD: load_ready=1; word k stored at bits [k*BUS_W +: BUS_W]; after word KEY_W/BUS_W-1 -> ARMED.
REQ-009 ARMED: load_ready=0; start loads counter n=min(bit_count,KEY_W), R0=(1,0), R1=(BASE_X,1), clears rebuilt-scalar register S'; n==0 -> CHECK, else -> ISSUE.
REQ-010 ISSUE (1 cycle): b=scalar[n-1]; b=1: dbl=R1, add=R0; b=0: dbl=R0, add=R1; step_start=1; S'[n-1]<=b; -> WAIT.
REQ-011 Operand outputs SHALL hold stable from ISSUE until step_done.
REQ-012 WAIT: on step_done, b=1: R1<=res_dbl, R0<=res_add; b=0: R0<=res_dbl, R1<=res_add; n<=n-1; n-1==0 -> CHECK else ISSUE.
REQ-013 step_done outside WAIT SHALL be ignored.
REQ-014 Each ladder bit SHALL take exactly 2 + step-engine latency cycles regardless of b (constant time).
REQ-015 CHECK (1 cycle): error<=1 if S'[n0-1:0] != scalar[n0-1:0] (n0 = counter value loaded at start); -> DRAIN.
REQ-016 DRAIN: streams R0.x then R0.z, least significant word first, 2*KEY_W/BUS_W words; word advances only on out_valid&out_ready; out_data stable while out_valid&!out_ready.
REQ-017 Last word accepted: done=1 for one cycle, -> ARMED (same scalar reusable by new start).
REQ-018 bit_count > KEY_W SHALL clamp to KEY_W.
REQ-019 start in any state other than ARMED SHALL be ignored; load_valid outside IDLE/LOAD SHALL be ignored.

Reset
REQ-020 reset SHALL force IDLE and clear scalar, S', R0, R1, counter, error, done, step_start, out_valid; load_ready=1 the cycle after release.
REQ-021 reset during WAIT SHALL discard any subsequent step_done.

Verification
REQ-022 KEY_W=16, BUS_W=8, stub step engine (latency 3): load 8'hA5, 8'h3C, start, bit_count=16 -> 16 step_start pulses, b sequence matches 16'h3CA5 MSB first, error=0.
REQ-023 bit_count=0 -> no step_start, DRAIN emits R0.x=1, R0.z=0 (four words 01,00,00,00), done pulse.
REQ-024 bit_count=20 with KEY_W=16 -> exactly 16 steps.
REQ-025 out_ready held low 5 cycles mid-drain -> out_data unchanged, no word lost or duplicated.
REQ-026 force S' bit flip during WAIT -> error=1 after CHECK, stays 1 through DRAIN and ARMED until next load.
REQ-027 reset asserted in WAIT, stub then returns step_done -> state IDLE, no register update, outputs at reset values.

Source files
------------

// File: rtl/ladder_sequencer.sv
// rtl/ladder_sequencer.sv - constant-time Montgomery-ladder sequencer
// Loads a scalar, walks it MSB first through an external step engine, drains R0.
module ladder_sequencer #(
  parameter int               BUS_W  = 56,
  parameter int               KEY_W  = 448,
  parameter int               CNT_W  = 9,
  parameter logic [KEY_W-1:0] BASE_X = KEY_W'(5)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [BUS_W-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
  input  logic [CNT_W-1:0] bit_count,
  output logic             step_start,
  output logic [KEY_W-1:0] step_dbl_x,
  output logic [KEY_W-1:0] step_dbl_z,
  output logic [KEY_W-1:0] step_add_x,
  output logic [KEY_W-1:0] step_add_z,
  output logic [KEY_W-1:0] step_base_x,
  input  logic             step_done,
  input  logic [KEY_W-1:0] res_dbl_x,
  input  logic [KEY_W-1:0] res_dbl_z,
  input  logic [KEY_W-1:0] res_add_x,
  input  logic [KEY_W-1:0] res_add_z,
  output logic             out_valid,
  output logic [BUS_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int NW = KEY_W / BUS_W;
  localparam int LW = (NW > 1) ? $clog2(NW) : 1;
  localparam int DW = $clog2(2 * NW);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARMED, S_ISSUE, S_WAIT, S_CHECK, S_DRAIN
  } state_t;

  state_t             r_state, w_next;
  logic [KEY_W-1:0]   r_scalar, r_sreb;
  logic [KEY_W-1:0]   r_r0x, r_r0z, r_r1x, r_r1z;
  logic [CNT_W-1:0]   r_n, r_n0;
  logic [LW-1:0]      r_lidx;
  logic [DW-1:0]      r_oidx;
  logic               r_error, r_done;

  logic               w_load_fire, w_out_fire, w_b, w_last_word, w_mismatch;
  logic [CNT_W-1:0]   w_idx, w_bc_clamp;
  logic [KEY_W-1:0]   w_scalar_sh, w_mask;
  logic [2*KEY_W-1:0] w_drain_vec;

  assign w_load_fire = load_valid & load_ready;
  assign w_out_fire  = out_valid & out_ready;
  assign w_idx       = r_n - CNT_W'(1);
  assign w_scalar_sh = r_scalar >> w_idx;
  assign w_b         = w_scalar_sh[0];
  assign w_bc_clamp  = (bit_count > CNT_W'(KEY_W)) ? CNT_W'(KEY_W) : bit_count;
  assign w_mask      = (r_n0 >= CNT_W'(KEY_W)) ? '1 : ((KEY_W'(1) << r_n0) - KEY_W'(1));
  assign w_mismatch  = |((r_sreb ^ r_scalar) & w_mask);
  assign w_drain_vec = {r_r0z, r_r0x};
  assign w_last_word = (r_oidx == DW'(2 * NW - 1));

  // Operand muxing depends only on the current bit, so both branches cost the same.
  assign step_dbl_x  = w_b ? r_r1x : r_r0x;
  assign step_dbl_z  = w_b ? r_r1z : r_r0z;
  assign step_add_x  = w_b ? r_r0x : r_r1x;
  assign step_add_z  = w_b ? r_r0z : r_r1z;
  assign step_base_x = BASE_X;
  assign out_data    = w_drain_vec[r_oidx * BUS_W +: BUS_W];
  assign done        = r_done;
  assign error       = r_error;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    step_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
        if (w_load_fire) w_next = (NW == 1) ? S_ARMED : S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (w_load_fire && r_lidx == LW'(NW - 1)) w_next = S_ARMED;
      end
      S_ARMED: begin
        busy = 1'b0;
        if (start) w_next = (w_bc_clamp == '0) ? S_CHECK : S_ISSUE;
      end
      S_ISSUE: begin
        step_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (step_done) w_next = (w_idx == '0) ? S_CHECK : S_ISSUE;
      end
      S_CHECK: w_next = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        if (w_out_fire && w_last_word) w_next = S_ARMED;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scalar <= '0;
      r_sreb   <= '0;
      r_r0x    <= '0;
      r_r0z    <= '0;
      r_r1x    <= '0;
      r_r1z    <= '0;
      r_n      <= '0;
      r_n0     <= '0;
      r_lidx   <= '0;
      r_oidx   <= '0;
      r_error  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_load_fire) begin
          r_scalar[0 +: BUS_W] <= load_data;
          r_error              <= 1'b0;
          r_lidx               <= LW'(1);
        end
        S_LOAD: if (w_load_fire) begin
          r_scalar[r_lidx * BUS_W +: BUS_W] <= load_data;
          r_lidx                            <= r_lidx + LW'(1);
        end
        S_ARMED: if (start) begin
          r_n    <= w_bc_clamp;
          r_n0   <= w_bc_clamp;
          r_r0x  <= KEY_W'(1);
          r_r0z  <= '0;
          r_r1x  <= BASE_X;
          r_r1z  <= KEY_W'(1);
          r_sreb <= '0;
        end
        // Rebuild the scalar from the bits actually consumed, for the consistency check.
        S_ISSUE: r_sreb <= r_sreb | (KEY_W'(w_b) << w_idx);
        S_WAIT: if (step_done) begin
          if (w_b) begin
            r_r1x <= res_dbl_x;
            r_r1z <= res_dbl_z;
            r_r0x <= res_add_x;
            r_r0z <= res_add_z;
          end else begin
            r_r0x <= res_dbl_x;
            r_r0z <= res_dbl_z;
            r_r1x <= res_add_x;
            r_r1z <= res_add_z;
          end
          r_n <= w_idx;
        end
        S_CHECK: begin
          if (w_mismatch) r_error <= 1'b1;
          r_oidx <= '0;
        end
        S_DRAIN: if (w_out_fire) begin
          r_oidx <= r_oidx + DW'(1);
          if (w_last_word) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ladder_sequencer.sv
// tb/tb_ladder_sequencer.sv - directed and random checks of ladder_sequencer
// A latency-3 stub step engine and a bit-level ladder model supply expected values.
module tb_ladder_sequencer;

  localparam int KW  = 16;
  localparam int BW  = 8;
  localparam int CW  = 9;
  localparam int LAT = 3;
  localparam logic [KW-1:0] BASE = 16'h0009;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [BW-1:0] load_data = '0;
  logic          load_ready;
  logic          start = 1'b0;
  logic [CW-1:0] bit_count = '0;
  logic          step_start;
  logic [KW-1:0] step_dbl_x, step_dbl_z, step_add_x, step_add_z, step_base_x;
  logic          step_done = 1'b0;
  logic [KW-1:0] res_dbl_x = '0, res_dbl_z = '0, res_add_x = '0, res_add_z = '0;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic          busy, done, error;

  int n_assert = 0;
  int n_fail   = 0;

  ladder_sequencer #(.BUS_W(BW), .KEY_W(KW), .CNT_W(CW), .BASE_X(BASE)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .bit_count(bit_count),
    .step_start(step_start), .step_dbl_x(step_dbl_x), .step_dbl_z(step_dbl_z),
    .step_add_x(step_add_x), .step_add_z(step_add_z), .step_base_x(step_base_x),
    .step_done(step_done), .res_dbl_x(res_dbl_x), .res_dbl_z(res_dbl_z),
    .res_add_x(res_add_x), .res_add_z(res_add_z), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_dbl(input logic [15:0] x, input logic [15:0] z);
    logic [15:0] nx, nz;
    nx = x * x + z * 16'd3 + 16'd7;
    nz = (x ^ 16'h5a5a) + z * 16'd5;
    return {nx, nz};
  endfunction

  function automatic logic [31:0] f_add(input logic [15:0] dx, input logic [15:0] dz,
                                        input logic [15:0] ax, input logic [15:0] az);
    logic [15:0] nx, nz;
    nx = dx * ax + dz + BASE;
    nz = (az * 16'd3) ^ dx ^ 16'h1234;
    return {nx, nz};
  endfunction

  // Stub step engine: results appear LAT+1 negedges after the issue cycle.
  int          pend = 0;
  int          cyc = 0;
  int          last_ss = -1;
  int          n_steps = 0;
  int          n_dones = 0;
  bit          chk_stab = 1'b1;
  logic [63:0] cap_ops;
  logic [63:0] log_ops[$];
  int          intervals[$];

  always @(negedge clk) begin
    logic [31:0] d, a;
    cyc++;
    step_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        step_done = 1'b1;
        n_dones++;
        if (chk_stab)
          chk("operand_stable", {step_dbl_x, step_dbl_z, step_add_x, step_add_z}, cap_ops);
      end
    end
    if (step_start) begin
      n_steps++;
      cap_ops = {step_dbl_x, step_dbl_z, step_add_x, step_add_z};
      log_ops.push_back(cap_ops);
      if (last_ss >= 0) intervals.push_back(cyc - last_ss);
      last_ss = cyc;
      d = f_dbl(step_dbl_x, step_dbl_z);
      a = f_add(step_dbl_x, step_dbl_z, step_add_x, step_add_z);
      {res_dbl_x, res_dbl_z} = d;
      {res_add_x, res_add_z} = a;
      pend = LAT + 1;
    end
  end

  logic [63:0] exp_ops[$];

  task automatic model_run(input logic [15:0] k, input int n,
                           output logic [15:0] fx, output logic [15:0] fz);
    logic [15:0] a0x, a0z, a1x, a1z;
    logic [31:0] d, a;
    a0x = 16'd1; a0z = 16'd0; a1x = BASE; a1z = 16'd1;
    exp_ops.delete();
    for (int i = n - 1; i >= 0; i--) begin
      if (k[i]) begin
        exp_ops.push_back({a1x, a1z, a0x, a0z});
        d = f_dbl(a1x, a1z);
        a = f_add(a1x, a1z, a0x, a0z);
        {a1x, a1z} = d;
        {a0x, a0z} = a;
      end else begin
        exp_ops.push_back({a0x, a0z, a1x, a1z});
        d = f_dbl(a0x, a0z);
        a = f_add(a0x, a0z, a1x, a1z);
        {a0x, a0z} = d;
        {a1x, a1z} = a;
      end
    end
    fx = a0x;
    fz = a0z;
  endtask

  logic [KW-1:0] force_val = '0;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load2(input logic [15:0] k, input string nm);
    load_valid = 1'b1;
    load_data  = k[7:0];
    chk({nm, "_ready0"}, 64'(load_ready), 64'd1);
    @(negedge clk);
    load_data = k[15:8];
    chk({nm, "_ready1"}, 64'(load_ready), 64'd1);
    @(negedge clk);
    load_valid = 1'b0;
    chk({nm, "_armed"}, 64'({load_ready, busy}), 64'd0);
  endtask

  task automatic run(input logic [15:0] k, input int bc, input bit stall,
                     input bit inject, input bit exp_err, input string nm);
    int          n, idx, stalled, cy;
    bit          forced;
    logic [15:0] fx, fz;
    logic [7:0]  ew[4];
    n = (bc > KW) ? KW : bc;
    model_run(k, n, fx, fz);
    ew[0] = fx[7:0]; ew[1] = fx[15:8]; ew[2] = fz[7:0]; ew[3] = fz[15:8];
    log_ops.delete();
    intervals.delete();
    n_steps = 0;
    last_ss = -1;
    forced  = 1'b0;
    start = 1'b1;
    bit_count = CW'(bc);
    @(negedge clk);
    start = 1'b0;
    for (cy = 0; cy < 400 && !out_valid; cy++) begin
      if (inject && !forced && n_steps == n) begin
        force_val = k ^ 16'h0001;
        force dut.r_sreb = force_val;
        forced = 1'b1;
      end
      @(negedge clk);
    end
    chk({nm, "_drain_reached"}, 64'(out_valid), 64'd1);
    idx = 0;
    stalled = 0;
    for (cy = 0; cy < 40 && idx < 4; cy++) begin
      if (stall && idx == 2 && stalled < 5) begin
        out_ready = 1'b0;
        chk($sformatf("%s_stall%0d", nm, stalled), {63'(out_data), out_valid}, {56'd0, ew[2], 1'b1});
        stalled++;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          chk($sformatf("%s_word%0d", nm, idx), 64'(out_data), 64'(ew[idx]));
          idx++;
        end
      end
      @(negedge clk);
    end
    chk({nm, "_word_count"}, 64'(idx), 64'd4);
    chk({nm, "_done_pulse"}, 64'(done), 64'd1);
    @(negedge clk);
    chk({nm, "_done_low"}, 64'({done, out_valid, busy, load_ready}), 64'd0);
    chk({nm, "_steps"}, 64'(n_steps), 64'(n));
    for (int i = 0; i < n && i < log_ops.size(); i++)
      chk($sformatf("%s_ops%0d", nm, i), log_ops[i], exp_ops[i]);
    for (int i = 0; i < intervals.size(); i++)
      chk($sformatf("%s_period%0d", nm, i), 64'(intervals[i]), 64'(2 + LAT));
    if (forced) release dut.r_sreb;
    chk({nm, "_error"}, 64'(error), 64'(exp_err));
  endtask

  initial begin
    int nd;
    logic [15:0] k;
    do_reset();
    chk("reset_outputs", 64'({load_ready, busy, out_valid, step_start, done, error}), 64'b100000);
    chk("reset_operands", {step_dbl_x, step_dbl_z, step_add_x, step_add_z}, 64'd0);
    chk("base_x", 64'(step_base_x), 64'(BASE));

    start = 1'b1; bit_count = 9'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_in_idle", 64'({busy, load_ready, 8'(n_steps)}), {54'd0, 2'b01, 8'd0});

    load2(16'h3CA5, "ld_a");
    run(16'h3CA5, 16, 1'b0, 1'b0, 1'b0, "full16");
    run(16'h3CA5, 0, 1'b0, 1'b0, 1'b0, "zero");

    load_valid = 1'b1; load_data = 8'hFF;
    repeat (2) @(negedge clk);
    chk("load_in_armed", 64'(load_ready), 64'd0);
    load_valid = 1'b0;
    run(16'h3CA5, 20, 1'b1, 1'b0, 1'b0, "clamp20");

    run(16'h3CA5, 16, 1'b0, 1'b1, 1'b1, "inject");
    repeat (3) @(negedge clk);
    chk("error_sticky_armed", 64'(error), 64'd1);
    run(16'h3CA5, 0, 1'b0, 1'b0, 1'b1, "inject_rerun");
    do_reset();
    chk("error_after_reset", 64'(error), 64'd0);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      k = 16'($urandom);
      load2(k, $sformatf("ld_r%0d", t));
      run(k, int'($urandom_range(1, 18)), t[0], 1'b0, 1'b0, $sformatf("rand%0d", t));
    end

    do_reset();
    load2(16'hB7E1, "ld_w");
    start = 1'b1; bit_count = 9'd16;
    @(negedge clk);
    start = 1'b0;
    for (int cy = 0; cy < 20 && n_steps == 0; cy++) @(negedge clk);
    @(negedge clk);
    chk("wait_reached", 64'({busy, step_start}), 64'b10);
    nd = n_dones;
    chk_stab = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("stray_done_seen", 64'(n_dones - nd), 64'd1);
    chk("wait_reset_ctrl", 64'({load_ready, busy, step_start, out_valid, error, done}), 64'b100000);
    chk("wait_reset_ops", {step_dbl_x, step_dbl_z, step_add_x, step_add_z}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
